sram_ctrl: RTL
==============

# sram_ctrl

MEM-stage interface between the MIPS pipeline and the board's external 16-bit asynchronous SRAM. It serves the same request set as the on-chip data memory: a 32-bit byte address, a store value, write enable and read enable. Each 32-bit word is moved as two 16-bit SRAM accesses. While an access is in flight the block holds `ready` low, which the hazard/freeze logic uses to stall the whole pipeline.

## Interface
Parameters:
- `ADDR_W`, 18: width of the SRAM halfword address.
- `WAIT_CYCLES`, 1: extra clock cycles held per halfword phase. Range 0..7.

Ports:
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `wr_en` input 1: store request from the MEM stage.
- `rd_en` input 1: load request from the MEM stage.
- `address` input 32: byte address. Bits [1:0] are ignored.
- `wdata` input 32: store value.
- `rdata` output 32: last completed read word.
- `ready` output 1: high when no access is pending or the current access completes this cycle.
- `sram_addr` output ADDR_W: SRAM halfword address.
- `sram_dq` inout 16: SRAM data bus.
- `sram_we_n`, `sram_oe_n`, `sram_ce_n`, `sram_ub_n`, `sram_lb_n` output 1 each: SRAM strobes, active-low.

## Operation
- State register has four states: IDLE, LO, HI, DONE. A phase counter of width 3 counts cycles within LO and HI.
- **Request capture:** in IDLE, a request (`wr_en|rd_en`) latches `address[ADDR_W:2]`, `wdata` and the op, then goes to LO.
  - If `wr_en` and `rd_en` are both high, the write wins and the read is dropped.
- **Address mapping:** `sram_addr = {word_addr, half}`.
  - LO uses half=0 and carries data[15:0].
  - HI uses half=1 and carries data[31:16].
- **Phase length:** LO and HI each last WAIT_CYCLES+1 cycles. The counter resets on every phase entry. Transitions are LO→HI→DONE→IDLE.
- **Strobes in LO/HI:**
  - `sram_ce_n`, `sram_ub_n` and `sram_lb_n` are 0.
  - On a write, `sram_we_n`=0, `sram_oe_n`=1, and `sram_dq` is driven with the halfword.
  - On a read, `sram_we_n`=1, `sram_oe_n`=0, and `sram_dq`=Z. The halfword is sampled on the clock edge that ends the phase's last cycle.
- **Strobes in IDLE/DONE:** all strobes are 1 and `sram_dq`=Z.
- **Read completion:** `rdata` is registered and loaded with {HI half, LO half} on the edge entering DONE. It holds until the next completed read. A write never changes `rdata`.
- **`ready`:** `ready = (state==IDLE && !(wr_en|rd_en)) || state==DONE`. This is combinational from state and the request inputs.
- **Upstream rules:**
  - The MEM stage holds `address`, `wdata` and the op stable while `ready`=0.
  - The pipeline advances on the edge ending DONE. A request seen in IDLE after that is treated as a new access.
- **Reset:** async reset, applied at any time including mid-access, forces:
  - state=IDLE and counter=0;
  - `rdata`=0 and `sram_addr`=0;
  - all strobes=1 and `sram_dq`=Z.
  
  A write in flight is abandoned; partial SRAM contents are not repaired.

## Timing
- A request first present in cycle 0 (IDLE) keeps `ready` low for cycles 0 through 2·WAIT_CYCLES+2. `ready` is high in cycle 2·WAIT_CYCLES+3, which is DONE.
  - With the default WAIT_CYCLES=1, that is 5 stall cycles with `ready` high in cycle 5.
- The LO phase spans cycles 1..WAIT_CYCLES+1. The HI phase spans the next WAIT_CYCLES+1 cycles.
- `sram_addr` changes only on phase entry. `sram_dq` drive and `sram_we_n` change together with it.
- `rdata` is valid from DONE onward.
- Back-to-back requests lose one IDLE cycle between accesses.

## Configuration
- `SRAM_CTRL_CACHE_EN` defined adds a one-entry read buffer holding a valid bit, a word-address tag and 32-bit data.
  - **Read hit:** in IDLE, a read with valid=1 and tag==word address goes directly to DONE. `ready` is low in cycle 0 and high in cycle 1. `rdata` is loaded from the buffer and the SRAM is not touched.
  - **Fill:** a completed SRAM read fills the buffer and sets valid.
  - **Write:** a write to the tagged address updates the buffer data at write capture (write-through). Other writes leave the buffer unchanged.
  - **Reset:** reset clears valid.
- Not defined: no buffer. Every read takes the full SRAM path.

## Test plan
- Reset mid-access: assert `rst` during HI of a write. Immediately `sram_we_n`=1 and `sram_dq`=Z. After release, state is IDLE, `rdata`=0, and `ready`=1 with no request.
- Write then read: write 0xDEADBEEF to address 0x40 with WAIT_CYCLES=1.
  - `ready` is low for exactly 5 cycles.
  - The SRAM model holds 0xBEEF at halfword 0x20 and 0xDEAD at 0x21.
  - A read of 0x40 returns `rdata`=0xDEADBEEF in DONE.
- Simultaneous enables: `wr_en`=`rd_en`=1 with `wdata`=0x12345678 at 0x80. The write is performed and `rdata` is unchanged.
- WAIT_CYCLES=0: a read stalls 3 cycles. The `sram_oe_n` low window is 2 cycles with the address changing between them.
- With `SRAM_CTRL_CACHE_EN`: after reading 0x100 (0xCAFEF00D), a repeat read of 0x100 gives `ready` high in cycle 1 with no `sram_ce_n` pulse. A write of 0x11112222 to 0x100 followed by a read returns 0x11112222 via a hit.

Source files
------------

// File: rtl/sram_ctrl.sv
// MEM-stage bridge to a 16-bit asynchronous SRAM: each 32-bit word moves as two halfword phases.
// Optional one-entry read buffer enabled by defining SRAM_CTRL_CACHE_EN.
`timescale 1ns/1ps
module sram_ctrl #(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [31:0]       address,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [15:0]       sram_dq,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              sram_ce_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    localparam logic [2:0] LP_LAST = 3'(WAIT_CYCLES);

    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          r_cnt;
    logic [2:0]          w_cnt_next;
    logic [ADDR_W-2:0]   r_word;
    logic [31:0]         r_wdata;
    logic                r_op_wr;
    logic [15:0]         r_lo;
    logic [31:0]         r_rdata;
    logic [ADDR_W-1:0]   r_sram_addr;
    logic                w_req;
    logic                w_phase_end;
    logic                w_hit;
    logic                w_active;
    logic [ADDR_W-2:0]   w_word_in;
    logic                w_unused;

    assign w_req       = wr_en | rd_en;
    assign w_word_in   = address[ADDR_W:2];
    assign w_phase_end = (r_cnt == LP_LAST);
    assign w_unused    = &{1'b0, address[31:ADDR_W+1], address[1:0]};

`ifdef SRAM_CTRL_CACHE_EN
    logic              r_valid;
    logic [ADDR_W-2:0] r_tag;
    logic [31:0]       r_cdata;

    // A simultaneous write wins, so a hit must be a pure read.
    assign w_hit = rd_en && !wr_en && r_valid && (r_tag == w_word_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_cdata <= '0;
        end else begin
            if (r_state == S_HI && w_phase_end && !r_op_wr) begin
                r_valid <= 1'b1;
                r_tag   <= r_word;
                r_cdata <= {sram_dq, r_lo};
            end
            if (r_state == S_IDLE && wr_en && r_valid && (r_tag == w_word_in)) begin
                r_cdata <= wdata;
            end
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (w_hit) begin
                    w_state_next = S_DONE;
                end else if (w_req) begin
                    w_state_next = S_LO;
                end
            end
            S_LO: begin
                if (w_phase_end) begin
                    w_state_next = S_HI;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 3'd1;
                end
            end
            S_HI: begin
                if (w_phase_end) begin
                    w_state_next = S_DONE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 3'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Address is updated only when a phase is entered, so it is stable through each phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word      <= '0;
            r_wdata     <= '0;
            r_op_wr     <= 1'b0;
            r_lo        <= '0;
            r_rdata     <= '0;
            r_sram_addr <= '0;
        end else begin
            if (r_state == S_IDLE && w_req && !w_hit) begin
                r_word      <= w_word_in;
                r_wdata     <= wdata;
                r_op_wr     <= wr_en;
                r_sram_addr <= {w_word_in, 1'b0};
            end
            if (r_state == S_LO && w_phase_end) begin
                r_sram_addr <= {r_word, 1'b1};
                if (!r_op_wr) begin
                    r_lo <= sram_dq;
                end
            end
            if (r_state == S_HI && w_phase_end && !r_op_wr) begin
                r_rdata <= {sram_dq, r_lo};
            end
`ifdef SRAM_CTRL_CACHE_EN
            if (r_state == S_IDLE && w_hit) begin
                r_rdata <= r_cdata;
            end
`endif
        end
    end

    assign w_active  = (r_state == S_LO) || (r_state == S_HI);
    assign sram_ce_n = !w_active;
    assign sram_ub_n = !w_active;
    assign sram_lb_n = !w_active;
    assign sram_we_n = !(w_active && r_op_wr);
    assign sram_oe_n = !(w_active && !r_op_wr);
    assign sram_dq   = (w_active && r_op_wr) ?
                       ((r_state == S_HI) ? r_wdata[31:16] : r_wdata[15:0]) : 16'bz;
    assign sram_addr = r_sram_addr;
    assign rdata     = r_rdata;
    assign ready     = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);

endmodule
